alu_wb_master: RTL and testbench

- Wishbone initiator for the ALU slave; the master end of the ALU request/ack interface.
- Accepts one ALU job at a time from a synth/DSP core over a valid/ready request channel and drives alu_cycle/alu_strobe.
- Holds mode, op and operands stable for the whole bus cycle, captures pl/pr on alu_ack, then returns the result over a valid/ready response channel.
- Sits between voice/filter engines and the ALU, in the same clock domain.

---
 rtl/alu_wb_master_pkg.sv | 24 ++
 rtl/alu_wb_master.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alu_wb_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_master_pkg
//  Description : Constants shared between the ALU slave and its Wishbone
//                initiator. These are the mode flag, the function-mode
//                selectors and the operand widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_wb_master_pkg;

  // Operand widths: A/B are multiplier inputs, C/P are accumulator width.
  localparam int ALU_AB_W = 18;
  localparam int ALU_C_W  = 48;

  // req_mode/alu_mode value that selects DSP mode. The other value selects
  // function mode, where the op field carries an ALU_FUNC_* selector.
  localparam logic ALU_MODE_DSP = 1'b1;

  localparam logic [7:0] ALU_FUNC_SIN          = 8'h01;
  localparam logic [7:0] ALU_FUNC_COS          = 8'h02;
  localparam logic [7:0] ALU_FUNC_INV_1_PLUS_X = 8'h03;

endpackage
`default_nettype wire

// File: rtl/alu_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wb_master
//  Description : Wishbone initiator for the ALU slave. It takes one job at a
//                time over a valid/ready request channel and runs one
//                pipelined Wishbone cycle for that job. Mode, op and operands
//                are held for the whole cycle. The pl/pr results are captured
//                on ack and returned over a valid/ready response channel.
//  Options     : ALU_WB_MASTER_TIMEOUT_EN - when defined, a job whose ack does
//                not arrive within TIMEOUT_CYCLES after strobe acceptance is
//                aborted. It then completes with rsp_err = 1 and zero results.
//  Ports       : clk, reset_n (async, active low)
//                req_*  : job request channel (valid/ready + mode/op/operands)
//                rsp_*  : result channel (valid/ready + pl/pr/err)
//                alu_*  : Wishbone CYC/STB/STALL/ACK plus operand/result buses
//                busy   : a job is in flight (state != IDLE)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_master
  import alu_wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  // Request channel
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_mode,
  input  logic [7:0]          req_op,
  input  logic [ALU_AB_W-1:0] req_al,
  input  logic [ALU_AB_W-1:0] req_bl,
  input  logic [ALU_AB_W-1:0] req_ar,
  input  logic [ALU_AB_W-1:0] req_br,
  input  logic [ALU_C_W-1:0]  req_cl,
  input  logic [ALU_C_W-1:0]  req_cr,
  // Response channel
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ALU_C_W-1:0]  rsp_pl,
  output logic [ALU_C_W-1:0]  rsp_pr,
  output logic                rsp_err,
  // Wishbone side
  output logic                alu_cycle,
  output logic                alu_strobe,
  input  logic                alu_stall,
  input  logic                alu_ack,
  output logic                alu_mode,
  output logic [7:0]          alu_op,
  output logic [ALU_AB_W-1:0] alu_al,
  output logic [ALU_AB_W-1:0] alu_bl,
  output logic [ALU_AB_W-1:0] alu_ar,
  output logic [ALU_AB_W-1:0] alu_br,
  output logic [ALU_C_W-1:0]  alu_cl,
  output logic [ALU_C_W-1:0]  alu_cr,
  input  logic [ALU_C_W-1:0]  alu_pl,
  input  logic [ALU_C_W-1:0]  alu_pr,
  // Status
  output logic                busy
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_STROBE   = 2'd1;
  localparam logic [1:0] c_WAIT_ACK = 2'd2;
  localparam logic [1:0] c_RESP     = 2'd3;

  // The timeout counter is 8 bits wide, so the parameter must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("alu_wb_master: TIMEOUT_CYCLES must be within 2..255");
  end

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;

  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [ALU_C_W-1:0]  r_rsp_pl;
  logic [ALU_C_W-1:0]  r_rsp_pr;
  logic                r_alu_cycle;
  logic                r_alu_strobe;
  logic                r_alu_mode;
  logic [7:0]          r_alu_op;
  logic [ALU_AB_W-1:0] r_alu_al;
  logic [ALU_AB_W-1:0] r_alu_bl;
  logic [ALU_AB_W-1:0] r_alu_ar;
  logic [ALU_AB_W-1:0] r_alu_br;
  logic [ALU_C_W-1:0]  r_alu_cl;
  logic [ALU_C_W-1:0]  r_alu_cr;
  logic                r_busy;

  logic                w_req_ready_nxt;
  logic                w_rsp_valid_nxt;
  logic [ALU_C_W-1:0]  w_rsp_pl_nxt;
  logic [ALU_C_W-1:0]  w_rsp_pr_nxt;
  logic                w_alu_cycle_nxt;
  logic                w_alu_strobe_nxt;
  logic                w_busy_nxt;

  logic                w_accept;
  logic                w_strobe_taken;
  logic                w_ack_take;
  logic                w_timeout;

  // A job is taken only when the registered ready is up. This keeps the
  // handshake honest in the first cycle after reset, while ready is still 0.
  assign w_accept       = (r_state == c_IDLE) && r_req_ready && req_valid;
  assign w_strobe_taken = (r_state == c_STROBE) && !alu_stall;
  // The slave may ack in the same cycle it accepts the strobe.
  assign w_ack_take     = alu_ack && (w_strobe_taken || (r_state == c_WAIT_ACK));

`ifdef ALU_WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic       r_rsp_err;
  logic       w_rsp_err_nxt;
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 8'd0;
    end else if (w_strobe_taken) begin
      r_cnt <= 8'd0;
    end else if (r_state == c_WAIT_ACK) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // An ack in the last allowed cycle wins over the timeout.
  assign w_timeout = (r_state == c_WAIT_ACK) && !alu_ack && (r_cnt == c_TIMEOUT_LAST);

  always_comb begin
    w_rsp_err_nxt = r_rsp_err;
    if (w_ack_take) begin
      w_rsp_err_nxt = 1'b0;
    end else if (w_timeout) begin
      w_rsp_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_rsp_err_nxt;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_STROBE;
        end
      end
      c_STROBE: begin
        if (w_strobe_taken) begin
          w_state_nxt = alu_ack ? c_RESP : c_WAIT_ACK;
        end
      end
      c_WAIT_ACK: begin
        if (alu_ack || w_timeout) begin
          w_state_nxt = c_RESP;
        end
      end
      c_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic. Every output is registered, so these are next-values
  // decoded from the state being entered.
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == c_IDLE);
    w_rsp_valid_nxt  = (w_state_nxt == c_RESP);
    w_alu_cycle_nxt  = (w_state_nxt == c_STROBE) || (w_state_nxt == c_WAIT_ACK);
    w_alu_strobe_nxt = (w_state_nxt == c_STROBE);
    w_busy_nxt       = (w_state_nxt != c_IDLE);
    w_rsp_pl_nxt     = r_rsp_pl;
    w_rsp_pr_nxt     = r_rsp_pr;
    if (w_ack_take) begin
      w_rsp_pl_nxt = alu_pl;
      w_rsp_pr_nxt = alu_pr;
    end else if (w_timeout) begin
      w_rsp_pl_nxt = '0;
      w_rsp_pr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_pl     <= '0;
      r_rsp_pr     <= '0;
      r_alu_cycle  <= 1'b0;
      r_alu_strobe <= 1'b0;
      r_alu_mode   <= 1'b0;
      r_alu_op     <= 8'd0;
      r_alu_al     <= '0;
      r_alu_bl     <= '0;
      r_alu_ar     <= '0;
      r_alu_br     <= '0;
      r_alu_cl     <= '0;
      r_alu_cr     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_pl     <= w_rsp_pl_nxt;
      r_rsp_pr     <= w_rsp_pr_nxt;
      r_alu_cycle  <= w_alu_cycle_nxt;
      r_alu_strobe <= w_alu_strobe_nxt;
      r_busy       <= w_busy_nxt;
      // Mode/op/operands load only on acceptance. They stay frozen until the
      // next job, because slave function-mode routing depends on them for
      // the whole bus cycle.
      if (w_accept) begin
        r_alu_mode <= req_mode;
        r_alu_op   <= req_op;
        r_alu_al   <= req_al;
        r_alu_bl   <= req_bl;
        r_alu_ar   <= req_ar;
        r_alu_br   <= req_br;
        r_alu_cl   <= req_cl;
        r_alu_cr   <= req_cr;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_pl     = r_rsp_pl;
  assign rsp_pr     = r_rsp_pr;
  assign alu_cycle  = r_alu_cycle;
  assign alu_strobe = r_alu_strobe;
  assign alu_mode   = r_alu_mode;
  assign alu_op     = r_alu_op;
  assign alu_al     = r_alu_al;
  assign alu_bl     = r_alu_bl;
  assign alu_ar     = r_alu_ar;
  assign alu_br     = r_alu_br;
  assign alu_cl     = r_alu_cl;
  assign alu_cr     = r_alu_cr;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_wb_master
//  Description : Directed self-checking bench for alu_wb_master. The bench
//                drives the Wishbone slave side (stall/ack/results) directly.
//                Inputs change on the falling edge, and outputs are sampled
//                on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_master;
  import alu_wb_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_mode;
  logic [7:0]  req_op;
  logic [17:0] req_al, req_bl, req_ar, req_br;
  logic [47:0] req_cl, req_cr;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [47:0] rsp_pl, rsp_pr;
  logic        alu_cycle, alu_strobe, alu_stall, alu_ack, alu_mode;
  logic [7:0]  alu_op;
  logic [17:0] alu_al, alu_bl, alu_ar, alu_br;
  logic [47:0] alu_cl, alu_cr, alu_pl, alu_pr;
  logic        busy;

  logic [278:0] all_outs;
  assign all_outs = {req_ready, rsp_valid, rsp_pl, rsp_pr, rsp_err, alu_cycle,
                     alu_strobe, alu_mode, alu_op, alu_al, alu_bl, alu_ar,
                     alu_br, alu_cl, alu_cr, busy};

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;  // accepted strobes (STB & !STALL)
  int rsp_cnt = 0;  // response handshakes

  always #5 clk = ~clk;

  alu_wb_master #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_op(req_op), .req_al(req_al), .req_bl(req_bl), .req_ar(req_ar),
    .req_br(req_br), .req_cl(req_cl), .req_cr(req_cr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pl(rsp_pl),
    .rsp_pr(rsp_pr), .rsp_err(rsp_err),
    .alu_cycle(alu_cycle), .alu_strobe(alu_strobe), .alu_stall(alu_stall),
    .alu_ack(alu_ack), .alu_mode(alu_mode), .alu_op(alu_op),
    .alu_al(alu_al), .alu_bl(alu_bl), .alu_ar(alu_ar), .alu_br(alu_br),
    .alu_cl(alu_cl), .alu_cr(alu_cr), .alu_pl(alu_pl), .alu_pr(alu_pr),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (reset_n && alu_strobe && !alu_stall) acc_cnt++;
    if (reset_n && rsp_valid && rsp_ready) rsp_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a job at the falling edge. Return at the falling edge after the
  // accepting rising edge (edge T).
  task automatic issue(input logic m, input logic [7:0] o,
                       input logic [17:0] a0, input logic [17:0] b0,
                       input logic [17:0] a1, input logic [17:0] b1,
                       input logic [47:0] c0, input logic [47:0] c1);
    req_mode = m; req_op = o; req_al = a0; req_bl = b0; req_ar = a1;
    req_br = b1; req_cl = c0; req_cr = c1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (all_outs !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", all_outs); end
    @(negedge clk); reset_n = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_dsp_job();
    int a0, r0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL dsp_ready got %b want 1", req_ready); end
    a0 = acc_cnt; r0 = rsp_cnt;
    issue(ALU_MODE_DSP, 8'h05, 18'h12345, 18'h00abc, 18'h3ffff, 18'h00001,
          48'h0123456789ab, 48'hfedcba987654);
    checks++; if ({alu_cycle, alu_strobe, busy, req_ready} !== 4'b1110) begin errors++; $display("FAIL dsp_start got %b want 1110", {alu_cycle, alu_strobe, busy, req_ready}); end
    checks++; if ({alu_mode, alu_op, alu_al, alu_br, alu_cr} !== {ALU_MODE_DSP, 8'h05, 18'h12345, 18'h00001, 48'hfedcba987654}) begin errors++; $display("FAIL dsp_operands got %h/%h/%h", alu_op, alu_al, alu_cr); end
    tick();  // T+1: strobe accepted
    checks++; if ({alu_cycle, alu_strobe} !== 2'b10) begin errors++; $display("FAIL dsp_strobe_drop got %b want 10", {alu_cycle, alu_strobe}); end
    tick(); tick(); tick();  // now after T+4
    alu_ack = 1'b1; alu_pl = 48'h000000001234; alu_pr = 48'h0000FFFF0000;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dsp_early_valid got %b want 0", rsp_valid); end
    tick();  // T+5
    alu_ack = 1'b0; alu_pl = 48'hdeaddeaddead; alu_pr = 48'hbeefbeefbeef;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dsp_valid got %b want 1", rsp_valid); end
    checks++; if ({rsp_pl, rsp_pr} !== {48'h000000001234, 48'h0000FFFF0000}) begin errors++; $display("FAIL dsp_result got %h %h want 000000001234 0000ffff0000", rsp_pl, rsp_pr); end
    checks++; if ({rsp_err, alu_cycle} !== 2'b00) begin errors++; $display("FAIL dsp_err_cyc got %b want 00", {rsp_err, alu_cycle}); end
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL dsp_strobe_count got %0d want 1", acc_cnt - a0); end
    rsp_ready = 1'b1;
    tick();  // T+6: handshake
    checks++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin errors++; $display("FAIL dsp_done got %b want 010", {rsp_valid, req_ready, busy}); end
    checks++; if (rsp_cnt - r0 !== 1) begin errors++; $display("FAIL dsp_rsp_count got %0d want 1", rsp_cnt - r0); end
    // Back-to-back job: strobing at T+7, slave acks on the acceptance cycle.
    issue(ALU_MODE_DSP, 8'h06, 18'h1, 18'h2, 18'h3, 18'h4, 48'h5, 48'h6);
    checks++; if ({alu_strobe, alu_op} !== {1'b1, 8'h06}) begin errors++; $display("FAIL b2b_strobe got %b/%h want 1/06", alu_strobe, alu_op); end
    alu_ack = 1'b1; alu_pl = 48'h000000000abc; alu_pr = 48'h000000000def;
    tick();
    alu_ack = 1'b0;
    checks++; if ({rsp_valid, alu_cycle, rsp_pl, rsp_pr} !== {2'b10, 48'h000000000abc, 48'h000000000def}) begin errors++; $display("FAIL b2b_fast_ack got %b%b %h %h", rsp_valid, alu_cycle, rsp_pl, rsp_pr); end
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got %b want 0", rsp_valid); end
  endtask

  task automatic test_stall();
    int a0, r0, hi;
    bit moved;
    a0 = acc_cnt; r0 = rsp_cnt; hi = 0; moved = 0;
    alu_stall = 1'b1;
    issue(1'b0, ALU_FUNC_COS, 18'h2aaaa, 18'h15555, 18'h00f0f, 18'h30303,
          48'h111122223333, 48'h444455556666);
    for (int i = 0; i < 5; i++) begin
      if (alu_strobe === 1'b1) hi++;
      if ({alu_op, alu_al, alu_bl, alu_ar, alu_br, alu_cl, alu_cr} !==
          {ALU_FUNC_COS, 18'h2aaaa, 18'h15555, 18'h00f0f, 18'h30303,
           48'h111122223333, 48'h444455556666}) moved = 1;
      if (i == 4) alu_stall = 1'b0;
      tick();
    end
    checks++; if (hi !== 5) begin errors++; $display("FAIL stall_strobe_len got %0d want 5", hi); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL stall_operands_stable got %b want 0", moved); end
    checks++; if ({alu_strobe, alu_cycle} !== 2'b01) begin errors++; $display("FAIL stall_release got %b want 01", {alu_strobe, alu_cycle}); end
    alu_ack = 1'b1; alu_pl = 48'h0000000000aa; alu_pr = 48'h0000000000bb;
    tick();
    alu_ack = 1'b0;
    checks++; if ({rsp_valid, rsp_pl, rsp_pr} !== {1'b1, 48'h0000000000aa, 48'h0000000000bb}) begin errors++; $display("FAIL stall_result got %b %h %h", rsp_valid, rsp_pl, rsp_pr); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    checks++; if ({acc_cnt - a0, rsp_cnt - r0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL stall_counts got %0d/%0d want 1/1", acc_cnt - a0, rsp_cnt - r0); end
  endtask

  task automatic test_func_sin();
    bit bad;
    bad = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sin_ready got %b want 1", req_ready); end
    issue(1'b0, ALU_FUNC_SIN, 18'h00100, 18'h0, 18'h00200, 18'h0, 48'h0, 48'h0);
    tick();  // strobe accepted
    for (int i = 0; i < 20; i++) begin
      if ({alu_cycle, alu_mode, alu_op, alu_al, alu_ar} !==
          {1'b1, 1'b0, ALU_FUNC_SIN, 18'h00100, 18'h00200} || rsp_valid !== 1'b0) bad = 1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL sin_hold got %b want 0", bad); end
    alu_ack = 1'b1; alu_pl = 48'h00007fff0001; alu_pr = 48'h800000000002;
    tick();
    alu_ack = 1'b0;
    checks++; if ({rsp_valid, rsp_err, alu_cycle, rsp_pl, rsp_pr} !== {3'b100, 48'h00007fff0001, 48'h800000000002}) begin errors++; $display("FAIL sin_result got %b%b%b %h %h", rsp_valid, rsp_err, alu_cycle, rsp_pl, rsp_pr); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit bad;
    bad = 0;
    issue(ALU_MODE_DSP, 8'h11, 18'h7, 18'h8, 18'h9, 18'ha, 48'hb, 48'hc);
    tick();
    alu_ack = 1'b1; alu_pl = 48'h123456789abc; alu_pr = 48'h0000000000cc;
    tick();
    alu_ack = 1'b0;
    // Second job is offered while the first response is stuck.
    req_mode = ALU_MODE_DSP; req_op = 8'h22; req_al = 18'h1; req_bl = 18'h1;
    req_ar = 18'h1; req_br = 18'h1; req_cl = 48'h1; req_cr = 48'h1; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin alu_ack = 1'b1; alu_pl = 48'hffffffffffff; end  // spurious
      else alu_ack = 1'b0;
      if ({rsp_valid, req_ready, alu_cycle, alu_strobe} !== 4'b1000 ||
          rsp_pl !== 48'h123456789abc || alu_op !== 8'h11) bad = 1;
      tick();
    end
    alu_ack = 1'b0;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_hold got %b want 0", bad); end
    checks++; if (rsp_pl !== 48'h123456789abc) begin errors++; $display("FAIL bp_spurious got %h want 123456789abc", rsp_pl); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, req_ready, alu_strobe} !== 3'b010) begin errors++; $display("FAIL bp_release got %b want 010", {rsp_valid, req_ready, alu_strobe}); end
    tick();
    req_valid = 1'b0;
    checks++; if ({alu_strobe, alu_op} !== {1'b1, 8'h22}) begin errors++; $display("FAIL bp_second_job got %b/%h want 1/22", alu_strobe, alu_op); end
    tick();
    alu_ack = 1'b1; alu_pl = 48'h2; alu_pr = 48'h3;
    tick();
    alu_ack = 1'b0;
    checks++; if ({rsp_valid, rsp_pl} !== {1'b1, 48'h2}) begin errors++; $display("FAIL bp_second_rsp got %b %h", rsp_valid, rsp_pl); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_spurious_idle();
    alu_ack = 1'b1; alu_pl = 48'h5a5a5a5a5a5a;
    tick();
    alu_ack = 1'b0;
    tick();
    checks++; if ({rsp_valid, busy, alu_cycle, req_ready} !== 4'b0001 || rsp_pl !== 48'h2) begin errors++; $display("FAIL idle_ack got %b %h", {rsp_valid, busy, alu_cycle, req_ready}, rsp_pl); end
  endtask

`ifdef ALU_WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit bad;
    bad = 0;
    issue(1'b0, 8'hFF, 18'h1, 18'h2, 18'h3, 18'h4, 48'h5, 48'h6);
    tick();  // strobe accepted, counter at 0
    for (int i = 0; i < 63; i++) begin
      if (alu_cycle !== 1'b1 || rsp_valid !== 1'b0) bad = 1;
      tick();
    end
    checks++; if (bad !== 1'b0 || alu_cycle !== 1'b1) begin errors++; $display("FAIL to_wait got %b/%b want 0/1", bad, alu_cycle); end
    tick();
    checks++; if ({alu_cycle, rsp_valid, rsp_err} !== 3'b011) begin errors++; $display("FAIL to_abort got %b want 011", {alu_cycle, rsp_valid, rsp_err}); end
    checks++; if ({rsp_pl, rsp_pr} !== 96'd0) begin errors++; $display("FAIL to_zero got %h %h want 0", rsp_pl, rsp_pr); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    issue(ALU_MODE_DSP, 8'h33, 18'h3, 18'h3, 18'h3, 18'h3, 48'h3, 48'h3);
    tick(); tick();  // in WAIT_ACK
    checks++; if (alu_cycle !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", alu_cycle); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (all_outs !== '0) begin errors++; $display("FAIL mid_reset_outs got %h want 0", all_outs); end
    @(negedge clk);
    reset_n = 1'b1;
    alu_ack = 1'b1; alu_pl = 48'h999;  // stale ack from the dropped cycle
    tick();
    alu_ack = 1'b0;
    checks++; if ({req_ready, rsp_valid, busy, alu_cycle} !== 4'b1000) begin errors++; $display("FAIL mid_after got %b want 1000", {req_ready, rsp_valid, busy, alu_cycle}); end
    tick();
    checks++; if ({rsp_valid, rsp_pl} !== {1'b0, 48'h0}) begin errors++; $display("FAIL mid_stale got %b %h want 0 0", rsp_valid, rsp_pl); end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_op = 8'h0;
    req_al = '0; req_bl = '0; req_ar = '0; req_br = '0; req_cl = '0; req_cr = '0;
    rsp_ready = 1'b0; alu_stall = 1'b0; alu_ack = 1'b0; alu_pl = '0; alu_pr = '0;
    test_reset();
    test_dsp_job();
    test_stall();
    test_func_sin();
    test_backpressure();
    test_spurious_idle();
`ifdef ALU_WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
